// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: ALU and load writebacks each buffer in a
// private 2-entry FIFO; one head per cycle is granted and registered onto the write port.
module regfile_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [4:0]  alu_address_i,
    input  logic [31:0] alu_data_i,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic [4:0]  mem_address_i,
    input  logic [31:0] mem_data_i,
    output logic        write_o,
    output logic [4:0]  reg_write_address_o,
    output logic [31:0] write_data_o,
    output logic [31:0] busy_mask_o,
    output logic        idle_o
);

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned TW    = 8;
    localparam int unsigned SW    = 3;
    localparam int unsigned CW    = 2;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned NREQ  = 2;
    localparam int unsigned ALU   = 0;
    localparam int unsigned MEM   = 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } entry_t;

    entry_t        fifo_q [NREQ][DEPTH];
    entry_t        fifo_d [NREQ][DEPTH];
    logic [CW-1:0] cnt_q  [NREQ];
    logic [CW-1:0] cnt_d  [NREQ];
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tag_q, tag_d;
    logic          write_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] busy_q, busy_d;
    logic          idle_q, idle_d;

    logic [NREQ-1:0] in_valid_c;
    logic [AW-1:0]   in_addr_c [NREQ];
    logic [DW-1:0]   in_data_c [NREQ];
    logic [NREQ-1:0] ready_c, accept_c, push_c, pop_c, head_v_c;
    logic            grant_alu_c, grant_mem_c, same_addr_c, alu_older_c;
    logic [TW-1:0]   tag_diff_c;
    entry_t          grant_entry_c;

    // Requester front-end: handshake and enqueue qualification.
    always_comb begin
        in_valid_c      = {mem_valid_i, alu_valid_i};
        in_addr_c[ALU]  = alu_address_i;
        in_addr_c[MEM]  = mem_address_i;
        in_data_c[ALU]  = alu_data_i;
        in_data_c[MEM]  = mem_data_i;
        ready_c         = '0;
        accept_c        = '0;
        push_c          = '0;
        head_v_c        = '0;
        for (int r = 0; r < int'(NREQ); r++) begin
            ready_c[r]  = !reset_i && (cnt_q[r] != CW'(DEPTH));
            accept_c[r] = in_valid_c[r] && ready_c[r];
            // r0 completes the handshake but is never buffered.
            push_c[r]   = accept_c[r] && (in_addr_c[r] != '0);
            head_v_c[r] = (cnt_q[r] != '0);
        end
    end

    // Head arbitration: same-address ordering, then starvation, then mem priority.
    always_comb begin
        tag_diff_c    = fifo_q[ALU][0].tag - fifo_q[MEM][0].tag;
        alu_older_c   = tag_diff_c[TW-1] || (tag_diff_c == '0);
        same_addr_c   = (&head_v_c) && (fifo_q[ALU][0].addr == fifo_q[MEM][0].addr);
        grant_alu_c   = head_v_c[ALU] &&
                        (!head_v_c[MEM] ||
                         (same_addr_c ? alu_older_c : (starve_q >= SW'(STARVE_LIMIT))));
        grant_mem_c   = head_v_c[MEM] && !grant_alu_c;
        pop_c         = {grant_mem_c, grant_alu_c};
        grant_entry_c = grant_alu_c ? fifo_q[ALU][0] : fifo_q[MEM][0];

        starve_d = starve_q;
        if (grant_alu_c) begin
            starve_d = '0;
        end else if (head_v_c[ALU] && (starve_q < SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end
        tag_d = tag_q + TW'(|accept_c);
    end

    // FIFO next state, busy mask and idle from the post-update contents.
    always_comb begin
        logic slot;
        busy_d = '0;
        slot   = 1'b0;
        for (int r = 0; r < int'(NREQ); r++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_d[r][i] = fifo_q[r][i];
            end
            cnt_d[r] = cnt_q[r] - CW'(pop_c[r]) + CW'(push_c[r]);
            slot     = ((cnt_q[r] - CW'(pop_c[r])) != '0);
            if (pop_c[r]) begin
                fifo_d[r][0] = fifo_q[r][1];
            end
            if (push_c[r]) begin
                fifo_d[r][slot] = '{addr: in_addr_c[r], data: in_data_c[r], tag: tag_q};
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (CW'(i) < cnt_d[r]) begin
                    busy_d = busy_d | (DW'(1) << fifo_d[r][i].addr);
                end
            end
        end
        idle_d = (cnt_d[ALU] == '0) && (cnt_d[MEM] == '0) && !(|pop_c);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int r = 0; r < int'(NREQ); r++) begin
                cnt_q[r] <= '0;
                for (int i = 0; i < int'(DEPTH); i++) begin
                    fifo_q[r][i] <= '0;
                end
            end
            starve_q <= '0;
            tag_q    <= '0;
            write_q  <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            busy_q   <= '0;
            idle_q   <= 1'b1;
        end else begin
            for (int r = 0; r < int'(NREQ); r++) begin
                cnt_q[r] <= cnt_d[r];
                for (int i = 0; i < int'(DEPTH); i++) begin
                    fifo_q[r][i] <= fifo_d[r][i];
                end
            end
            starve_q <= starve_d;
            tag_q    <= tag_d;
            write_q  <= grant_alu_c || grant_mem_c;
            if (grant_alu_c || grant_mem_c) begin
                waddr_q <= grant_entry_c.addr;
                wdata_q <= grant_entry_c.data;
            end
            busy_q   <= busy_d;
            idle_q   <= idle_d;
        end
    end

    assign alu_ready_o         = ready_c[ALU];
    assign mem_ready_o         = ready_c[MEM];
    assign write_o             = write_q;
    assign reg_write_address_o = waddr_q;
    assign write_data_o        = wdata_q;
    assign busy_mask_o         = busy_q;
    assign idle_o              = idle_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: per-cycle vector table plus
// hand-written ordering, r0-discard and mid-operation reset sequences.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        alu_valid_i, alu_ready_o;
    logic [4:0]  alu_address_i;
    logic [31:0] alu_data_i;
    logic        mem_valid_i, mem_ready_o;
    logic [4:0]  mem_address_i;
    logic [31:0] mem_data_i;
    logic        write_o;
    logic [4:0]  reg_write_address_o;
    logic [31:0] write_data_o;
    logic [31:0] busy_mask_o;
    logic        idle_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0]  wq_addr [$];
    logic [31:0] wq_data [$];

    always #5 clk = ~clk;

    regfile_write_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .alu_valid_i         (alu_valid_i),
        .alu_ready_o         (alu_ready_o),
        .alu_address_i       (alu_address_i),
        .alu_data_i          (alu_data_i),
        .mem_valid_i         (mem_valid_i),
        .mem_ready_o         (mem_ready_o),
        .mem_address_i       (mem_address_i),
        .mem_data_i          (mem_data_i),
        .write_o             (write_o),
        .reg_write_address_o (reg_write_address_o),
        .write_data_o        (write_data_o),
        .busy_mask_o         (busy_mask_o),
        .idle_o              (idle_o)
    );

    // Write-port monitor used by the sequence checks.
    always @(negedge clk) begin
        if (write_o === 1'b1) begin
            wq_addr.push_back(reg_write_address_o);
            wq_data.push_back(write_data_o);
        end
    end

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        chk;
        logic        wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] busy;
        logic        idle;
        logic        ar;
        logic        mr;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic drive(input logic rst, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        reset_i       = rst;
        alu_valid_i   = av;
        alu_address_i = aa;
        alu_data_i    = ad;
        mem_valid_i   = mv;
        mem_address_i = ma;
        mem_data_i    = md;
    endtask

    task automatic cycle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_writes();
        wq_addr.delete();
        wq_data.delete();
    endtask

    initial begin
        // rst av aa ad      mv ma md       chk wr wa wd       busy      idle ar mr
        vecs[0]  = '{1,0,0,0,       0,0,0,        0, 0,0,0,        32'h0,    1,0,0};
        vecs[1]  = '{1,0,0,0,       0,0,0,        1, 0,0,0,        32'h0,    1,0,0};
        vecs[2]  = '{0,1,5,32'hAA,  0,0,0,        1, 0,0,0,        32'h0,    1,1,1};
        vecs[3]  = '{0,0,0,0,       0,0,0,        1, 0,0,0,        32'h20,   0,1,1};
        vecs[4]  = '{0,0,0,0,       0,0,0,        1, 1,5,32'hAA,   32'h0,    0,1,1};
        vecs[5]  = '{0,0,0,0,       0,0,0,        1, 0,5,32'hAA,   32'h0,    1,1,1};
        vecs[6]  = '{0,1,3,32'h11,  1,4,32'h22,   1, 0,5,32'hAA,   32'h0,    1,1,1};
        vecs[7]  = '{0,0,0,0,       0,0,0,        1, 0,5,32'hAA,   32'h18,   0,1,1};
        vecs[8]  = '{0,0,0,0,       0,0,0,        1, 1,4,32'h22,   32'h08,   0,1,1};
        vecs[9]  = '{0,0,0,0,       0,0,0,        1, 1,3,32'h11,   32'h0,    0,1,1};
        vecs[10] = '{0,0,0,0,       0,0,0,        1, 0,3,32'h11,   32'h0,    1,1,1};
        vecs[11] = '{0,1,7,32'h77,  1,1,32'h100,  1, 0,3,32'h11,   32'h0,    1,1,1};
        vecs[12] = '{0,0,0,0,       1,2,32'h101,  1, 0,3,32'h11,   32'h82,   0,1,1};
        vecs[13] = '{0,0,0,0,       1,3,32'h102,  1, 1,1,32'h100,  32'h84,   0,1,1};
        vecs[14] = '{0,0,0,0,       1,4,32'h103,  1, 1,2,32'h101,  32'h88,   0,1,1};
        vecs[15] = '{0,0,0,0,       1,5,32'h104,  1, 1,3,32'h102,  32'h90,   0,1,1};
        vecs[16] = '{0,0,0,0,       1,6,32'h105,  1, 1,7,32'h77,   32'h30,   0,1,0};
        vecs[17] = '{0,0,0,0,       0,0,0,        1, 1,4,32'h103,  32'h20,   0,1,1};
        vecs[18] = '{0,0,0,0,       0,0,0,        1, 1,5,32'h104,  32'h0,    0,1,1};
        vecs[19] = '{0,0,0,0,       0,0,0,        1, 0,5,32'h104,  32'h0,    1,1,1};
        vecs[20] = '{0,1,8,32'h8,   1,9,32'h9,    1, 0,5,32'h104,  32'h0,    1,1,1};
        vecs[21] = '{0,0,0,0,       0,0,0,        1, 0,5,32'h104,  32'h300,  0,1,1};
        vecs[22] = '{0,0,0,0,       0,0,0,        1, 1,9,32'h9,    32'h100,  0,1,1};
        vecs[23] = '{0,0,0,0,       0,0,0,        1, 1,8,32'h8,    32'h0,    0,1,1};
        vecs[24] = '{0,0,0,0,       0,0,0,        1, 0,8,32'h8,    32'h0,    1,1,1};

        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].rst, vecs[k].av, vecs[k].aa, vecs[k].ad,
                  vecs[k].mv, vecs[k].ma, vecs[k].md);
            @(negedge clk);
            if (vecs[k].chk) begin
                check($sformatf("c%0d_write", k),     32'(write_o),             32'(vecs[k].wr));
                check($sformatf("c%0d_waddr", k),     32'(reg_write_address_o), 32'(vecs[k].wa));
                check($sformatf("c%0d_wdata", k),     write_data_o,             vecs[k].wd);
                check($sformatf("c%0d_busy", k),      busy_mask_o,              vecs[k].busy);
                check($sformatf("c%0d_idle", k),      32'(idle_o),              32'(vecs[k].idle));
                check($sformatf("c%0d_alu_ready", k), 32'(alu_ready_o),         32'(vecs[k].ar));
                check($sformatf("c%0d_mem_ready", k), 32'(mem_ready_o),         32'(vecs[k].mr));
            end
            @(posedge clk);
            #1;
        end

        // ALU r9 then mem r9 one cycle later: written in acceptance order.
        clear_writes();
        drive(0, 1, 9, 32'h1, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 1, 9, 32'h2);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle();
        check("seq_r9_count", 32'(wq_addr.size()), 32'd2);
        if (wq_addr.size() == 2) begin
            check("seq_r9_addr0", 32'(wq_addr[0]), 32'd9);
            check("seq_r9_data0", wq_data[0],      32'h1);
            check("seq_r9_addr1", 32'(wq_addr[1]), 32'd9);
            check("seq_r9_data1", wq_data[1],      32'h2);
        end

        // Same-cycle acceptance to r9: ALU value goes first despite mem priority.
        clear_writes();
        drive(0, 1, 9, 32'hA1, 1, 9, 32'hB2);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle();
        check("same_r9_count", 32'(wq_addr.size()), 32'd2);
        if (wq_addr.size() == 2) begin
            check("same_r9_data0", wq_data[0], 32'hA1);
            check("same_r9_data1", wq_data[1], 32'hB2);
        end

        // r0 write: handshake completes, nothing is written or marked busy.
        clear_writes();
        drive(0, 1, 0, 32'hDEAD, 0, 0, 0);
        @(negedge clk);
        check("r0_ready", 32'(alu_ready_o), 32'd1);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("r0_write_%0d", i), 32'(write_o),  32'd0);
            check($sformatf("r0_busy_%0d", i),  busy_mask_o,   32'd0);
            check($sformatf("r0_idle_%0d", i),  32'(idle_o),   32'd1);
            @(posedge clk);
            #1;
        end
        check("r0_no_writes", 32'(wq_addr.size()), 32'd0);

        // Load both FIFOs, then pulse reset for one cycle with requests still asserted.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 5'(10 + i), 32'(32'h1000 + i), 1, 5'(20 + i), 32'(32'h2000 + i));
            cycle();
        end
        @(negedge clk);
        check("preload_busy_nonzero", 32'(busy_mask_o != 0), 32'd1);
        @(posedge clk);
        #1;
        drive(1, 1, 5'd11, 32'h3333, 1, 5'd21, 32'h4444);
        @(negedge clk);
        check("rst_alu_ready", 32'(alu_ready_o), 32'd0);
        check("rst_mem_ready", 32'(mem_ready_o), 32'd0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        clear_writes();
        @(negedge clk);
        check("post_rst_write",     32'(write_o),             32'd0);
        check("post_rst_waddr",     32'(reg_write_address_o), 32'd0);
        check("post_rst_wdata",     write_data_o,             32'd0);
        check("post_rst_idle",      32'(idle_o),              32'd1);
        check("post_rst_alu_ready", 32'(alu_ready_o),         32'd1);
        check("post_rst_mem_ready", 32'(mem_ready_o),         32'd1);
        check("post_rst_busy",      busy_mask_o,              32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cycle();
        check("post_rst_no_writes", 32'(wq_addr.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
